booth_mult_unit: RTL and testbench

Sequential radix-2 Booth multiplier holding the MIPS `hi`/`lo` registers. It executes R-type `mult` (funct 0x18), which the ALU control decoder encodes. It consumes the operands, steps the hi/lo universal-shift datapath with a modulus-32 down counter, and reports its state on `mulst` back to the decoder. While a multiply is in flight it drops the program-counter write enable, which stalls the multicycle core; `mfhi`/`mflo` read its `hi`/`lo` outputs.

---
 rtl/mult_pkg.sv | 32 +++
 rtl/booth_mult_unit_if.sv | 24 ++
 rtl/booth_mult_unit_step.sv | 32 +++
 rtl/booth_mult_unit.sv | 94 +++++++++
 tb/tb_booth_mult_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the hi/lo multiply unit: mulst state codes, step count,
// and the R-type funct codes the ALU control decoder matches on.
package mult_pkg;

    localparam int MUL_STEPS = 32;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;

    typedef enum logic [2:0] {
        MUL_IDLE = 3'd0,
        MUL_RUN  = 3'd1,
        MUL_DONE = 3'd2
    } mul_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the {lo[0], lo[-1]} bit pair.
    function automatic booth_op_e booth_sel(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_unit_if.sv
// Issue/result bundle between the ALU control decoder and the multiply unit.
interface booth_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       mulst;
    logic             busy;
    logic             done;
    logic             pc_we;

    modport master (
        output start, rs_val, rt_val,
        input  hi, lo, mulst, busy, done, pc_we
    );

    modport slave (
        input  start, rs_val, rt_val,
        output hi, lo, mulst, busy, done, pc_we
    );
endinterface

// File: rtl/booth_mult_unit_step.sv
// One combinational radix-2 Booth step: conditional add/sub of the multiplicand
// into the accumulator, then arithmetic right shift of {acc, lo, q_m1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] lo,
    input  logic             q_m1,
    input  logic [WIDTH:0]   mcand,
    output logic [WIDTH:0]   acc_nx,
    output logic [WIDTH-1:0] lo_nx,
    output logic             q_m1_nx
);
    logic [WIDTH:0] sum;

    // Wraps modulo 2^(WIDTH+1); the guard bit keeps the true value in range.
    always_comb begin
        sum = acc;
        case (booth_sel(lo[0], q_m1))
            BOOTH_ADD: sum = acc + mcand;
            BOOTH_SUB: sum = acc - mcand;
            default:   sum = acc;
        endcase
    end

    assign acc_nx  = {sum[WIDTH], sum[WIDTH:1]};
    assign lo_nx   = {sum[0], lo[WIDTH-1:1]};
    assign q_m1_nx = lo[0];

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential Booth multiplier owning the MIPS hi/lo registers; stalls the PC
// from the mult issue cycle until the product is ready.
module booth_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MUL_STEPS
) (
    input logic              clk,
    input logic              rst_n,
    booth_mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    mul_state_e       state;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] lo;
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] lo_nx;
    logic             q_m1_nx;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .lo      (lo),
        .q_m1    (q_m1),
        .mcand   (mcand),
        .acc_nx  (acc_nx),
        .lo_nx   (lo_nx),
        .q_m1_nx (q_m1_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MUL_IDLE;
            acc    <= '0;
            mcand  <= '0;
            lo     <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        lo     <= bus.rt_val;
                        q_m1   <= 1'b0;
                        mcand  <= {bus.rs_val[WIDTH-1], bus.rs_val};
                        cnt    <= CW'(WIDTH - 1);
                        state  <= MUL_RUN;
                        busy_q <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    acc  <= acc_nx;
                    lo   <= lo_nx;
                    q_m1 <= q_m1_nx;
                    if (cnt == '0) begin
                        state  <= MUL_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL_DONE: begin
                    // start is deliberately ignored here; a new mult waits for IDLE.
                    state  <= MUL_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= MUL_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = acc[WIDTH-1:0];
    assign bus.lo    = lo;
    assign bus.mulst = state;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    // The start term holds the PC on the issue cycle itself.
    assign bus.pc_we = (state == MUL_DONE) | ((state == MUL_IDLE) & ~bus.start);

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: expected products queued at issue,
// compared when done pulses.
module tb_booth_mult_unit;
    localparam int W     = 32;
    localparam int N_RND = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    booth_mult_unit_if #(.WIDTH(W)) bus ();

    booth_mult_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic issue_low;
    logic [63:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("prod", {bus.hi, bus.lo}, sb.pop_front());
        end
    end

    // Waits for IDLE, drives start with operands; leaves start high.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        int n = 0;
        @(negedge clk);
        while (bus.mulst != 3'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 64'(n), 64'd0);
        bus.start  = 1'b1;
        bus.rs_val = a;
        bus.rt_val = b;
        #1;
        issue_low = ~bus.pc_we;
        if (push) sb.push_back(ref_mul(a, b));
    endtask

    task automatic wait_done(output int lat, output int lows, input bit keep);
        lat  = 0;
        lows = 0;
        do begin
            @(negedge clk);
            if (!keep) bus.start = 1'b0;
            #1;
            lat++;
            if (!bus.pc_we) lows++;
            if (lat == 16) chk("run_state", {bus.mulst, bus.busy, bus.done}, {3'd1, 1'b1, 1'b0});
        end while (!bus.done && lat < 60);
        if (lat >= 60) chk("done_timeout", 64'(lat), 64'd33);
    endtask

    initial begin
        int lat, lows, d0;
        logic [31:0] a, b;
        bus.start  = 1'b0;
        bus.rs_val = '0;
        bus.rt_val = '0;

        #1;
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_ctl", {bus.mulst, bus.busy, bus.done, bus.pc_we}, {3'd0, 1'b0, 1'b0, 1'b1});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 3 x 5: latency and stall length.
        issue(32'd3, 32'd5, 1'b1);
        wait_done(lat, lows, 1'b0);
        chk("lat_3x5", 64'(lat), 64'd33);
        chk("stall_3x5", 64'(lows + int'(issue_low)), 64'd33);
        chk("val_3x5", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        chk("done_pc_we", {bus.mulst, bus.pc_we}, {3'd2, 1'b1});
        @(negedge clk); #1;
        chk("post_done", {bus.mulst, bus.done, bus.pc_we}, {3'd0, 1'b0, 1'b1});
        chk("hold_3x5", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        issue(-32'sd7, 32'd6, 1'b1);
        wait_done(lat, lows, 1'b0);
        chk("val_m7x6", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(lat, lows, 1'b0);
        chk("val_min_min", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        wait_done(lat, lows, 1'b0);
        chk("val_min_max", {bus.hi, bus.lo}, 64'hC000_0000_8000_0000);

        // start held through RUN and DONE: one multiply, then reissue in IDLE.
        d0 = done_cnt;
        issue(32'd1234, -32'sd99, 1'b1);
        wait_done(lat, lows, 1'b1);
        chk("hold_lat", 64'(lat), 64'd33);
        chk("hold_done_pcwe", 64'(bus.pc_we), 64'd1);
        @(negedge clk); #1;
        chk("reissue_idle", {bus.mulst, bus.pc_we}, {3'd0, 1'b0});
        sb.push_back(ref_mul(32'd1234, -32'sd99));
        wait_done(lat, lows, 1'b0);
        chk("reissue_lat", 64'(lat), 64'd33);
        chk("hold_count", 64'(done_cnt - d0), 64'd2);

        // Asynchronous reset at RUN step 10.
        issue(32'h1234_5678, 32'h0BAD_F00D, 1'b0);
        repeat (10) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("arst_ctl", {bus.mulst, bus.busy, bus.done, bus.pc_we}, {3'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

        // Random signed pairs, with occasional corner operands.
        for (int i = 0; i < N_RND; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            issue(a, b, 1'b1);
            wait_done(lat, lows, 1'b0);
        end

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
